model_test_mac_pipe: RTL

- Pipelined signed multiply-accumulate; the sequential successor to the combinational `*_mul_*s_*s_*` multiplier cells in the generated model datapath.
- Multiplies `din0 × din1` through `NUM_STAGE` product registers and accumulates a framed sequence of products (`in_first` … `in_last`).
- Emits one saturated result per frame.
- Used for dense and conv dot products where a bare multiplier plus HLS adder tree costs too many DSPs.

---
 rtl/model_test_mac_pkg.sv | 52 +++++
 rtl/model_test_mul_pipe.sv | 62 ++++++
 rtl/model_test_mac_pipe.sv | 87 ++++++++
 3 files changed

// File: rtl/model_test_mac_pkg.sv
// Shared widths, legal-range constants and narrowing helper for the
// pipelined multiply-accumulate datapath.
`timescale 1ns/1ps
package model_test_mac_pkg;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 4;

    // Widest accumulator the narrowing helper can take.
    localparam int NARROW_W = 64;

    typedef struct packed {
        logic                       ovf;
        logic signed [NARROW_W-1:0] result;
    } narrow_t;

    function automatic int prod_width(input int a, input int b);
        return a + b;
    endfunction

    // value carries in_w meaningful bits; result holds the out_w-bit answer
    // sign-extended to NARROW_W, ovf flags a clamp (en=1) or a lossy wrap (en=0).
    function automatic narrow_t sat_narrow(input logic signed [NARROW_W-1:0] value,
                                           input int in_w, input int out_w,
                                           input logic en);
        logic signed [NARROW_W-1:0] v;
        logic signed [NARROW_W-1:0] hi;
        logic signed [NARROW_W-1:0] lo;
        logic signed [NARROW_W-1:0] wrapped;
        narrow_t r;
        v       = (value <<< (NARROW_W - in_w)) >>> (NARROW_W - in_w);
        hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        wrapped = (v <<< (NARROW_W - out_w)) >>> (NARROW_W - out_w);
        r.ovf    = 1'b0;
        r.result = v;
        if (en) begin
            if (v > hi) begin
                r.ovf    = 1'b1;
                r.result = hi;
            end else if (v < lo) begin
                r.ovf    = 1'b1;
                r.result = lo;
            end
        end else begin
            r.result = wrapped;
            r.ovf    = (wrapped != v);
        end
        return r;
    endfunction

endpackage

// File: rtl/model_test_mul_pipe.sv
// NUM_STAGE-deep signed multiplier with the frame sideband (valid/first/last)
// travelling alongside the product.
`timescale 1ns/1ps
module model_test_mul_pipe
    import model_test_mac_pkg::*;
#(
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 12,
    parameter int din1_WIDTH = 7,
    localparam int PW        = prod_width(din0_WIDTH, din1_WIDTH)
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic                         tail_valid,
    output logic                         tail_first,
    output logic                         tail_last,
    output logic signed [PW-1:0]         tail_prod
);

    logic signed [PW-1:0]  prod_d;
    logic [NUM_STAGE-1:0]  vld_q;
    logic [NUM_STAGE-1:0]  fst_q;
    logic [NUM_STAGE-1:0]  lst_q;
    logic signed [PW-1:0]  prod_q [NUM_STAGE];

    // Both operands widened to the full product width first, so the product is exact.
    assign prod_d = PW'(din0) * PW'(din1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q <= '0;
            fst_q <= '0;
            lst_q <= '0;
            // NOTE: the product array is plain flops, not RAM, so it takes the async reset with the rest of the pipe.
            for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
        end else if (ce) begin
            // NOTE: non-blocking assignments so each stage shifts from its pre-edge neighbour.
            vld_q[0]  <= in_valid;
            fst_q[0]  <= in_valid & in_first;
            lst_q[0]  <= in_valid & in_last;
            prod_q[0] <= prod_d;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_q[i]  <= vld_q[i-1];
                fst_q[i]  <= fst_q[i-1];
                lst_q[i]  <= lst_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign tail_valid = vld_q[NUM_STAGE-1];
    assign tail_first = fst_q[NUM_STAGE-1];
    assign tail_last  = lst_q[NUM_STAGE-1];
    assign tail_prod  = prod_q[NUM_STAGE-1];

endmodule

// File: rtl/model_test_mac_pipe.sv
// Pipelined signed multiply-accumulate: framed dot product with one narrowed
// (saturated or wrapped) result per frame.
`timescale 1ns/1ps
module model_test_mac_pipe
    import model_test_mac_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 12,
    parameter int din1_WIDTH = 7,
    parameter int acc_WIDTH  = 24,
    parameter int dout_WIDTH = 16,
    parameter int SAT_EN     = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic                         out_valid,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic                         out_ovf
);

    localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX || acc_WIDTH < PW ||
        dout_WIDTH > acc_WIDTH || acc_WIDTH > NARROW_W || ID < 0) begin : g_bad_param
        $error("model_test_mac_pipe: illegal parameter combination");
    end

    logic                        tail_valid;
    logic                        tail_first;
    logic                        tail_last;
    logic signed [PW-1:0]        tail_prod;
    logic signed [acc_WIDTH-1:0] acc_q;
    logic signed [acc_WIDTH-1:0] prod_ext;
    logic signed [acc_WIDTH-1:0] acc_next;
    narrow_t                     nr;

    model_test_mul_pipe #(
        .NUM_STAGE  (NUM_STAGE),
        .din0_WIDTH (din0_WIDTH),
        .din1_WIDTH (din1_WIDTH)
    ) u_mul (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ce         (ce),
        .in_valid   (in_valid),
        .in_first   (in_first),
        .in_last    (in_last),
        .din0       (din0),
        .din1       (din1),
        .tail_valid (tail_valid),
        .tail_first (tail_first),
        .tail_last  (tail_last),
        .tail_prod  (tail_prod)
    );

    // acc_next already includes the tail term, so the last beat's result is
    // narrowed in the same cycle it is accumulated.
    always_comb begin
        prod_ext = acc_WIDTH'(tail_prod);
        acc_next = tail_first ? prod_ext : acc_q + prod_ext;
        nr       = sat_narrow(NARROW_W'(acc_next), acc_WIDTH, dout_WIDTH, SAT_EN != 0);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q     <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_ovf   <= 1'b0;
        end else if (ce) begin
            if (tail_valid) acc_q <= acc_next;
            out_valid <= tail_valid & tail_last;
            if (tail_valid & tail_last) begin
                dout    <= nr.result[dout_WIDTH-1:0];
                out_ovf <= nr.ovf;
            end
        end
    end

endmodule
